// File: rtl/ysyx_24100006_pkg.sv
// Shared definitions for the ysyx_24100006 EXE redirect slice: jump class
// encoding, redirect FSM states and the architectural reset PC.
package ysyx_24100006_pkg;

  localparam logic [2:0] JMP_NONE = 3'd0;
  localparam logic [2:0] JMP_JAL  = 3'd1;
  localparam logic [2:0] JMP_JALR = 3'd2;
  localparam logic [2:0] JMP_BEQ  = 3'd3;
  localparam logic [2:0] JMP_BNE  = 3'd4;
  localparam logic [2:0] JMP_BLT  = 3'd5;
  localparam logic [2:0] JMP_BGE  = 3'd6;
  localparam logic [2:0] JMP_CSR  = 3'd7;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FENCE_REQ  = 2'd1,
    FENCE_WAIT = 2'd2
  } redirect_state_e;

  function automatic logic is_branch(input logic [2:0] jump);
    return (jump >= JMP_BEQ) && (jump <= JMP_BGE);
  endfunction

endpackage

// File: rtl/ysyx_24100006_br_cmp.sv
// Combinational branch resolver: evaluates BEQ/BNE/BLT(U)/BGE(U) over full-width
// operands; any non-branch jump class reports not-taken.
module ysyx_24100006_br_cmp
  import ysyx_24100006_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      jump_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            taken
);

  logic w_eq;
  logic w_lt;

  // Unsigned flag only matters for the ordered compares
  always_comb begin
    w_eq = (a_i == b_i);
    if (unsigned_i) begin
      w_lt = (a_i < b_i);
    end else begin
      w_lt = ($signed(a_i) < $signed(b_i));
    end
  end

  always_comb begin
    case (jump_i)
      JMP_BEQ: taken = w_eq;
      JMP_BNE: taken = ~w_eq;
      JMP_BLT: taken = w_lt;
      JMP_BGE: taken = ~w_lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100006_exe_redirect.sv
// EXE-stage redirect unit: resolves jumps, branches, traps and fence.i, and emits
// a registered one-cycle flush. Branch statistics: define YSYX_24100006_BRANCH_STAT_EN.
module ysyx_24100006_exe_redirect
  import ysyx_24100006_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      jump_i,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] alu_a_data_i,
  input  logic [XLEN-1:0] alu_b_data_i,
  input  logic [XLEN-1:0] pc_add_imm_i,
  input  logic [XLEN-1:0] pc_j_m_e_n_i,
  input  logic [XLEN-1:0] pc_add_4_i,
  input  logic            is_fence_i_i,
  input  logic            irq_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            flush_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            icache_flush_req_o,
  input  logic            icache_flush_ack_i
`ifdef YSYX_24100006_BRANCH_STAT_EN
  ,
  output logic [31:0]     stat_branch_o,
  output logic [31:0]     stat_taken_o,
  output logic [31:0]     stat_flush_o
`endif
);

  redirect_state_e r_state;
  redirect_state_e w_next_state;

  logic            r_flush;
  logic            r_icache_req;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] r_fence_pc;

  logic            w_open;
  logic            w_fire;
  logic            w_taken;
  logic            w_redirect;
  logic            w_fence_go;
  logic [XLEN-1:0] w_target;
  logic            w_unused_alu_op;

  assign w_unused_alu_op = |alu_op_i[2:0];

  ysyx_24100006_br_cmp #(
    .XLEN (XLEN)
  ) u_br_cmp (
    .jump_i     (jump_i),
    .unsigned_i (alu_op_i[3]),
    .a_i        (alu_a_data_i),
    .b_i        (alu_b_data_i),
    .taken      (w_taken)
  );

  // Handshake: closed while a fence is in flight and during the flush cycle
  always_comb begin
    w_open    = (r_state == IDLE) & ~r_flush;
    in_ready  = out_ready & w_open;
    out_valid = in_valid & w_open;
    w_fire    = in_valid & out_ready & w_open;
  end

  // Redirect priority: irq, CSR jump, JALR, JAL, taken branch, then fence.i
  always_comb begin
    w_redirect = 1'b1;
    w_fence_go = 1'b0;
    w_target   = pc_add_imm_i;
    if (irq_i) begin
      w_target = pc_j_m_e_n_i;
    end else if (jump_i == JMP_CSR) begin
      w_target = pc_j_m_e_n_i;
    end else if (jump_i == JMP_JALR) begin
      w_target = {pc_j_m_e_n_i[XLEN-1:1], 1'b0};
    end else if (jump_i == JMP_JAL) begin
      w_target = pc_add_imm_i;
    end else if (w_taken) begin
      w_target = pc_add_imm_i;
    end else if (is_fence_i_i) begin
      w_redirect = 1'b0;
      w_fence_go = 1'b1;
    end else begin
      w_redirect = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state: an ack seen on the first FENCE_REQ cycle is honoured at once
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_fire & w_fence_go) begin
          w_next_state = FENCE_REQ;
        end else begin
          w_next_state = IDLE;
        end
      end
      FENCE_REQ: begin
        if (icache_flush_ack_i) begin
          w_next_state = FENCE_WAIT;
        end else begin
          w_next_state = FENCE_REQ;
        end
      end
      FENCE_WAIT: w_next_state = IDLE;
      default:    w_next_state = IDLE;
    endcase
  end

  // Registered outputs: flush pulse, I-cache request and redirect target
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_flush       <= 1'b0;
      r_icache_req  <= 1'b0;
      r_redirect_pc <= RESET_PC;
    end else begin
      r_flush      <= (w_fire & w_redirect) | (r_state == FENCE_WAIT);
      r_icache_req <= (w_next_state == FENCE_REQ);
      if (w_fire & w_redirect) begin
        r_redirect_pc <= w_target;
      end else if (r_state == FENCE_WAIT) begin
        r_redirect_pc <= r_fence_pc;
      end else begin
        r_redirect_pc <= r_redirect_pc;
      end
    end
  end

  // Fall-through PC of the accepted fence.i, replayed when the flush completes
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fence_pc <= RESET_PC;
    end else if (w_fire & w_fence_go) begin
      r_fence_pc <= pc_add_4_i;
    end else begin
      r_fence_pc <= r_fence_pc;
    end
  end

  assign flush_o            = r_flush;
  assign icache_flush_req_o = r_icache_req;
  assign redirect_pc_o      = r_redirect_pc;

`ifdef YSYX_24100006_BRANCH_STAT_EN
  logic [31:0] r_stat_branch;
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_flush;
  logic        w_fire_branch;

  assign w_fire_branch = w_fire & is_branch(jump_i);

  // Free-running statistics, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_branch <= 32'd0;
      r_stat_taken  <= 32'd0;
      r_stat_flush  <= 32'd0;
    end else begin
      r_stat_branch <= r_stat_branch + {31'd0, w_fire_branch};
      r_stat_taken  <= r_stat_taken + {31'd0, w_fire_branch & w_taken};
      r_stat_flush  <= r_stat_flush + {31'd0, r_flush};
    end
  end

  assign stat_branch_o = r_stat_branch;
  assign stat_taken_o  = r_stat_taken;
  assign stat_flush_o  = r_stat_flush;
`endif

endmodule

// File: tb/tb_ysyx_24100006_exe_redirect.sv
// Self-checking bench for ysyx_24100006_exe_redirect: directed scenarios plus
// randomized instructions checked against a transaction-level redirect model.
module tb_ysyx_24100006_exe_redirect;

  localparam logic [31:0] RST_PC = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  jump_i;
  logic [3:0]  alu_op_i;
  logic [31:0] alu_a_data_i;
  logic [31:0] alu_b_data_i;
  logic [31:0] pc_add_imm_i;
  logic [31:0] pc_j_m_e_n_i;
  logic [31:0] pc_add_4_i;
  logic        is_fence_i_i;
  logic        irq_i;
  logic        out_valid;
  logic        out_ready;
  logic        flush_o;
  logic [31:0] redirect_pc_o;
  logic        icache_flush_req_o;
  logic        icache_flush_ack_i;
`ifdef YSYX_24100006_BRANCH_STAT_EN
  logic [31:0] stat_branch_o;
  logic [31:0] stat_taken_o;
  logic [31:0] stat_flush_o;
  int          n_branch;
  int          n_taken;
  int          n_flush;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_pc;

  ysyx_24100006_exe_redirect #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .jump_i             (jump_i),
    .alu_op_i           (alu_op_i),
    .alu_a_data_i       (alu_a_data_i),
    .alu_b_data_i       (alu_b_data_i),
    .pc_add_imm_i       (pc_add_imm_i),
    .pc_j_m_e_n_i       (pc_j_m_e_n_i),
    .pc_add_4_i         (pc_add_4_i),
    .is_fence_i_i       (is_fence_i_i),
    .irq_i              (irq_i),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .flush_o            (flush_o),
    .redirect_pc_o      (redirect_pc_o),
    .icache_flush_req_o (icache_flush_req_o),
    .icache_flush_ack_i (icache_flush_ack_i)
`ifdef YSYX_24100006_BRANCH_STAT_EN
    ,
    .stat_branch_o      (stat_branch_o),
    .stat_taken_o       (stat_taken_o),
    .stat_flush_o       (stat_flush_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] j, input logic [3:0] op,
                       input logic [31:0] a, b, imm, jmen, pc4,
                       input logic fence, irq);
    jump_i       = j;
    alu_op_i     = op;
    alu_a_data_i = a;
    alu_b_data_i = b;
    pc_add_imm_i = imm;
    pc_j_m_e_n_i = jmen;
    pc_add_4_i   = pc4;
    is_fence_i_i = fence;
    irq_i        = irq;
  endtask

  // Architectural redirect rule for one accepted instruction
  function automatic void ref_redirect(input logic [2:0] j, input logic [3:0] op,
                                       input logic [31:0] a, b, imm, jmen,
                                       input logic irq, output logic redir,
                                       output logic [31:0] tgt, output logic taken);
    int sa;
    int sb;
    bit lt;
    sa = a;
    sb = b;
    lt = op[3] ? (a < b) : (sa < sb);
    taken = (j == 3'd3 && a == b) || (j == 3'd4 && a != b) ||
            (j == 3'd5 && lt) || (j == 3'd6 && !lt);
    redir = 1'b1;
    if (irq || j == 3'd7) tgt = jmen;
    else if (j == 3'd2) tgt = jmen & 32'hFFFF_FFFE;
    else if (j == 3'd1 || taken) tgt = imm;
    else begin
      redir = 1'b0;
      tgt   = 32'h0;
    end
  endfunction

  task automatic apply_reset;
    reset    = 1'b0;
    in_valid = 1'b0;
    tick;
    tick;
    reset  = 1'b1;
    exp_pc = RST_PC;
  endtask

  task automatic test_reset;
    out_ready = 1'b1;
    apply_reset;
    #1;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush_o); end
    checks++; if (icache_flush_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", icache_flush_req_o); end
    checks++; if (redirect_pc_o !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h want %h", redirect_pc_o, RST_PC); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_beq;
    drive(3'd3, 4'd0, 32'd5, 32'd5, 32'h3000_0040, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL beq_accept: got rdy=%b vld=%b want 1 1", in_ready, out_valid); end
    tick;
    checks++; if (flush_o !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b want 1", flush_o); end
    checks++; if (redirect_pc_o !== 32'h3000_0040) begin errors++; $display("FAIL beq_pc: got %h want 30000040", redirect_pc_o); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL beq_drop: got rdy=%b vld=%b want 0 0", in_ready, out_valid); end
    in_valid = 1'b0;
    tick;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL beq_pulse: got %b want 0", flush_o); end
    checks++; if (redirect_pc_o !== 32'h3000_0040) begin errors++; $display("FAIL beq_hold: got %h want 30000040", redirect_pc_o); end
    exp_pc = 32'h3000_0040;
  endtask

  task automatic test_blt;
    drive(3'd5, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h3000_0080, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000_0080) begin errors++; $display("FAIL blt_signed: got flush=%b pc=%h want 1 30000080", flush_o, redirect_pc_o); end
    tick;
    drive(3'd5, 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'h3000_00C0, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL bltu_flush: got %b want 0", flush_o); end
    checks++; if (redirect_pc_o !== 32'h3000_0080) begin errors++; $display("FAIL bltu_hold: got %h want 30000080", redirect_pc_o); end
    exp_pc = 32'h3000_0080;
  endtask

  task automatic test_jalr;
    drive(3'd2, 4'd0, 32'h0, 32'h0, 32'h0, 32'h3000_0103, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL jalr_fwd: got %b want 1", out_valid); end
    tick;
    in_valid = 1'b0;
    checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000_0102) begin errors++; $display("FAIL jalr_pc: got flush=%b pc=%h want 1 30000102", flush_o, redirect_pc_o); end
    tick;
    exp_pc = 32'h3000_0102;
  endtask

  task automatic test_fence;
    int req_cycles;
    bit seen_ack;
    icache_flush_ack_i = 1'b0;
    drive(3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000_0010, 1'b1, 1'b0);
    in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fence_fwd: got %b want 1", out_valid); end
    tick;
    in_valid = 1'b0;
    req_cycles = 0;
    seen_ack = 1'b0;
    for (int c = 0; c < 8 && !seen_ack; c++) begin
      checks++; if (icache_flush_req_o !== 1'b1 || in_ready !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL fence_req: got req=%b rdy=%b flush=%b want 1 0 0", icache_flush_req_o, in_ready, flush_o); end
      req_cycles++;
      if (req_cycles == 3) begin
        icache_flush_ack_i = 1'b1;
        seen_ack = 1'b1;
      end
      tick;
    end
    icache_flush_ack_i = 1'b0;
    checks++; if (icache_flush_req_o !== 1'b0 || flush_o !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL fence_wait: got req=%b flush=%b rdy=%b want 0 0 0", icache_flush_req_o, flush_o, in_ready); end
    tick;
    checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000_0010 || in_ready !== 1'b0) begin errors++; $display("FAIL fence_flush: got flush=%b pc=%h rdy=%b want 1 30000010 0", flush_o, redirect_pc_o, in_ready); end
    tick;
    checks++; if (flush_o !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fence_done: got flush=%b rdy=%b want 0 1", flush_o, in_ready); end
    // ack already high when the request first rises
    drive(3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000_0200, 1'b1, 1'b0);
    in_valid = 1'b1;
    icache_flush_ack_i = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (icache_flush_req_o !== 1'b1) begin errors++; $display("FAIL fence_fast_req: got %b want 1", icache_flush_req_o); end
    tick;
    checks++; if (icache_flush_req_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL fence_fast_wait: got req=%b flush=%b want 0 0", icache_flush_req_o, flush_o); end
    tick;
    icache_flush_ack_i = 1'b0;
    checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000_0200) begin errors++; $display("FAIL fence_fast_flush: got flush=%b pc=%h want 1 30000200", flush_o, redirect_pc_o); end
    tick;
    exp_pc = 32'h3000_0200;
  endtask

  task automatic test_reset_mid_fence;
    drive(3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000_0300, 1'b1, 1'b0);
    in_valid = 1'b1;
    icache_flush_ack_i = 1'b0;
    tick;
    in_valid = 1'b0;
    reset = 1'b0;
    tick;
    checks++; if (icache_flush_req_o !== 1'b0 || flush_o !== 1'b0 || redirect_pc_o !== RST_PC) begin errors++; $display("FAIL rst_fence: got req=%b flush=%b pc=%h want 0 0 %h", icache_flush_req_o, flush_o, redirect_pc_o, RST_PC); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_fence_idle: got rdy=%b want 1", in_ready); end
    reset = 1'b1;
    icache_flush_ack_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (flush_o !== 1'b0 || icache_flush_req_o !== 1'b0) begin errors++; $display("FAIL rst_fence_abandon: got flush=%b req=%b want 0 0", flush_o, icache_flush_req_o); end
    end
    icache_flush_ack_i = 1'b0;
    exp_pc = RST_PC;
  endtask

  task automatic test_irq_stall;
    drive(3'd3, 4'd0, 32'd1, 32'd2, 32'h3000_0400, 32'h3000_0500, 32'h0, 1'b0, 1'b1);
    in_valid = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL irq_stall_hs: got rdy=%b vld=%b want 0 1", in_ready, out_valid); end
      tick;
      checks++; if (flush_o !== 1'b0 || redirect_pc_o !== exp_pc) begin errors++; $display("FAIL irq_stall_flush: got flush=%b pc=%h want 0 %h", flush_o, redirect_pc_o, exp_pc); end
    end
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    checks++; if (flush_o !== 1'b1 || redirect_pc_o !== 32'h3000_0500) begin errors++; $display("FAIL irq_fire: got flush=%b pc=%h want 1 30000500", flush_o, redirect_pc_o); end
    tick;
    exp_pc = 32'h3000_0500;
  endtask

  task automatic test_random;
    logic [2:0]  j;
    logic [3:0]  op;
    logic [31:0] a, b, imm, jmen, pc4;
    logic        fence, irq, redir, taken;
    logic [31:0] tgt;
    int          stalls;
    apply_reset;
`ifdef YSYX_24100006_BRANCH_STAT_EN
    n_branch = 0; n_taken = 0; n_flush = 0;
`endif
    for (int k = 0; k < 60; k++) begin
      j     = 3'($urandom_range(0, 7));
      op    = 4'($urandom);
      a     = $urandom;
      b     = ($urandom_range(0, 3) == 0) ? a : $urandom;
      imm   = $urandom;
      jmen  = $urandom;
      pc4   = $urandom;
      irq   = ($urandom_range(0, 7) == 0);
      fence = ($urandom_range(0, 3) == 0);
      ref_redirect(j, op, a, b, imm, jmen, irq, redir, tgt, taken);
      if (!redir) fence = 1'b0;
      drive(j, op, a, b, imm, jmen, pc4, fence, irq);
      in_valid = 1'b1;
      stalls = $urandom_range(0, 2);
      for (int s = 0; s < stalls; s++) begin
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rnd_stall_hs: k=%0d got rdy=%b vld=%b want 0 1", k, in_ready, out_valid); end
        tick;
        checks++; if (flush_o !== 1'b0 || redirect_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_stall: k=%0d got flush=%b pc=%h want 0 %h", k, flush_o, redirect_pc_o, exp_pc); end
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready: k=%0d got %b want 1", k, in_ready); end
      tick;
      if (redir) exp_pc = tgt;
`ifdef YSYX_24100006_BRANCH_STAT_EN
      if (j >= 3'd3 && j <= 3'd6) n_branch++;
      if (taken) n_taken++;
      if (redir) n_flush++;
`endif
      checks++; if (flush_o !== redir || redirect_pc_o !== exp_pc) begin errors++; $display("FAIL rnd_redirect: k=%0d j=%0d got flush=%b pc=%h want %b %h", k, j, flush_o, redirect_pc_o, redir, exp_pc); end
      checks++; if (in_ready !== !redir) begin errors++; $display("FAIL rnd_after: k=%0d got rdy=%b want %b", k, in_ready, !redir); end
      in_valid = 1'b0;
      if (redir) begin
        tick;
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL rnd_pulse: k=%0d got %b want 0", k, flush_o); end
      end
    end
    tick;
`ifdef YSYX_24100006_BRANCH_STAT_EN
    checks++; if (stat_branch_o !== 32'(n_branch) || stat_taken_o !== 32'(n_taken) || stat_flush_o !== 32'(n_flush)) begin errors++; $display("FAIL stats: got %0d %0d %0d want %0d %0d %0d", stat_branch_o, stat_taken_o, stat_flush_o, n_branch, n_taken, n_flush); end
`endif
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    icache_flush_ack_i = 1'b0;
    exp_pc = RST_PC;
    drive(3'd0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset;
    test_beq;
    test_blt;
    test_jalr;
    test_fence;
    test_reset_mid_fence;
    test_irq_stall;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
